// File: rtl/kc_intc_pkg.sv
// kc_intc_pkg
//   Shared definitions for the KC-LS1u+ interrupt controller:
//   register window offsets, controller state encoding and the
//   maximum number of request lines the 6-bit interrupt code can name.
package kc_intc_pkg;

    localparam int MAX_SRC = 64;

    // Byte offsets inside the 32-byte register window
    localparam logic [4:0] OFS_ENABLE  = 5'h00;  // 8 bytes
    localparam logic [4:0] OFS_PENDING = 5'h08;  // 8 bytes
    localparam logic [4:0] OFS_EDGE    = 5'h10;  // 8 bytes
    localparam logic [4:0] OFS_IVT     = 5'h18;  // 3 bytes, little-endian
    localparam logic [4:0] OFS_CTRL    = 5'h1B;
    localparam logic [4:0] OFS_CUR     = 5'h1C;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/kc_intc_prio_enc.sv
// kc_intc_prio_enc
//   Fixed-priority encoder, lowest index wins.
//   Ports:
//     req   in  N_SRC - request vector
//     valid out 1     - any request present
//     index out 6     - index of the lowest set request (0 when none)
module kc_intc_prio_enc #(
    parameter int N_SRC = 16
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [5:0]       index
);

    // Scan high to low so the last hit (lowest index) is what remains.
    always_comb begin
        index = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) index = 6'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/kc_ls1u_intc.sv
// kc_ls1u_intc
//   Memory-mapped interrupt controller feeding the KC-LS1u+ core.
//   Latches up to 64 edge/level request lines, picks the lowest
//   eligible index and holds INT/INTCODE until software writes EOI.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     irq      in N_SRC   request lines
//     daddr    in 24      core data address
//     dread    in 1       core read strobe
//     dwrite   in 1       core write strobe
//     wdata    in 8       core write data
//     rdata    out 8      register read data (combinational, 0 when not read)
//     rsel     out 1      daddr inside the 32-byte window
//     INT      out 1      interrupt request
//     INTCODE  out 6      code of the presented interrupt
//     IVT_addr out 24     vector table base
//   Build option: define KC_INTC_SYNC_EN to put a 2-flop synchronizer on
//   every irq line (adds 2 cycles to all irq->INT latencies).
module kc_ls1u_intc
    import kc_intc_pkg::*;
#(
    parameter int          N_SRC     = 16,
    parameter logic [23:0] BASE_ADDR = 24'hFFFF00,
    parameter logic [23:0] IVT_RESET = 24'h000100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic [23:0]      daddr,
    input  logic             dread,
    input  logic             dwrite,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic             rsel,
    output logic             INT,
    output logic [5:0]       INTCODE,
    output logic [23:0]      IVT_addr
);

    // ---------------- address decode ----------------
    logic [23:0] off;
    logic [4:0]  ofs;
    logic        wr;

    assign off  = daddr - BASE_ADDR;
    assign rsel = (off < 24'd32);
    assign ofs  = off[4:0];
    assign wr   = dwrite & rsel;

    logic wr_en, wr_pnd, wr_edge, wr_eoi;
    assign wr_en   = wr && (ofs[4:3] == OFS_ENABLE[4:3]);
    assign wr_pnd  = wr && (ofs[4:3] == OFS_PENDING[4:3]);
    assign wr_edge = wr && (ofs[4:3] == OFS_EDGE[4:3]);
    assign wr_eoi  = wr && (ofs == OFS_CUR);

    // ---------------- request input ----------------
    logic [N_SRC-1:0] irq_s;

`ifdef KC_INTC_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
        end
    end
    assign irq_s = sync2_q;
`else
    assign irq_s = irq;
`endif

    // ---------------- registers ----------------
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] edge_q,   edge_d;
    logic [N_SRC-1:0] pend_q,   pend_d;   // latched bits of edge sources
    logic [N_SRC-1:0] irq_q;
    logic [23:0]      ivt_q,    ivt_d;
    logic             gie_q,    gie_d;
    state_e           state_q,  state_d;
    logic [5:0]       cur_q,    cur_d;

    logic [N_SRC-1:0] rise, pend_now, clr;
    logic             eoi_fire;

    assign rise     = irq_s & ~irq_q;
    // Edge set is folded in combinationally so an edge in cycle N can be
    // arbitrated in N and presented in N+1, same as a level source.
    assign pend_now = (edge_q & (pend_q | rise)) | (~edge_q & irq_s);
    assign eoi_fire = wr_eoi && (state_q == ST_ACTIVE);

    // Byte-lane writes to the per-source vectors; bytes past N_SRC simply
    // have no bits to land in.
    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        clr      = '0;
        for (int n = 0; n < N_SRC; n++) begin
            if (ofs[2:0] == 3'(n / 8)) begin
                if (wr_en)   enable_d[n] = wdata[n % 8];
                if (wr_edge) edge_d[n]   = wdata[n % 8];
                if (wr_pnd)  clr[n]      = wdata[n % 8];
            end
            if (eoi_fire && (cur_q == 6'(n))) clr[n] = 1'b1;
        end
    end

    // Set wins over clear; non-edge sources never hold a latched bit.
    assign pend_d = ((pend_q & ~clr) | rise) & edge_q;

    always_comb begin
        ivt_d = ivt_q;
        gie_d = gie_q;
        if (wr) begin
            case (ofs)
                OFS_IVT:        ivt_d[7:0]   = wdata;
                OFS_IVT + 5'd1: ivt_d[15:8]  = wdata;
                OFS_IVT + 5'd2: ivt_d[23:16] = wdata;
                OFS_CTRL:       gie_d        = wdata[0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= '0;
            edge_q   <= '0;
            pend_q   <= '0;
            irq_q    <= '0;
            ivt_q    <= IVT_RESET;
            gie_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            edge_q   <= edge_d;
            pend_q   <= pend_d;
            irq_q    <= irq_s;
            ivt_q    <= ivt_d;
            gie_q    <= gie_d;
        end
    end

    // ---------------- arbitration ----------------
    logic       win_vld;
    logic [5:0] win_idx;

    kc_intc_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .req   (pend_now & enable_q),
        .valid (win_vld),
        .index (win_idx)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            ST_IDLE: begin
                if (gie_q && win_vld) begin
                    state_d = ST_ACTIVE;
                    cur_d   = win_idx;
                end
            end
            ST_ACTIVE: begin
                // Only EOI releases the presented code; config changes don't.
                if (wr_eoi) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        INT     = (state_q == ST_ACTIVE);
        INTCODE = cur_q;
    end

    assign IVT_addr = ivt_q;

    // ---------------- read mux ----------------
    logic [7:0] en_byte, pnd_byte, edge_byte, rd_byte;

    always_comb begin
        en_byte   = '0;
        pnd_byte  = '0;
        edge_byte = '0;
        for (int n = 0; n < N_SRC; n++) begin
            if (ofs[2:0] == 3'(n / 8)) begin
                en_byte[n % 8]   = enable_q[n];
                pnd_byte[n % 8]  = pend_now[n];
                edge_byte[n % 8] = edge_q[n];
            end
        end
    end

    always_comb begin
        rd_byte = '0;
        case (ofs[4:3])
            OFS_ENABLE[4:3]:  rd_byte = en_byte;
            OFS_PENDING[4:3]: rd_byte = pnd_byte;
            OFS_EDGE[4:3]:    rd_byte = edge_byte;
            default: begin
                case (ofs)
                    OFS_IVT:        rd_byte = ivt_q[7:0];
                    OFS_IVT + 5'd1: rd_byte = ivt_q[15:8];
                    OFS_IVT + 5'd2: rd_byte = ivt_q[23:16];
                    OFS_CTRL:       rd_byte = {7'b0, gie_q};
                    OFS_CUR:        rd_byte = {(state_q == ST_ACTIVE), 1'b0, cur_q};
                    default:        rd_byte = '0;
                endcase
            end
        endcase
    end

    assign rdata = (rsel && dread) ? rd_byte : 8'h00;

endmodule
